// File: rtl/ctrl_pkg.sv
// Purpose : shared widths, reset PC and PC-command priority encodings for Control/addr_sequencer.
// Latency : n/a (definitions only).
// Backpressure: n/a.
package ctrl_pkg;

  localparam int         DEF_ADDR_W      = 8;
  localparam int         DEF_LIT_W       = 32;
  localparam logic [7:0] DEF_RESET_PC    = 8'h00;
  localparam int         DEF_STACK_DEPTH = 4;

  // PC command selected each cycle, in ascending priority.
  localparam int CMD_W = 3;
  typedef logic [CMD_W-1:0] cmd_t;

  localparam cmd_t CMD_NONE = 3'd0;
  localparam cmd_t CMD_INC  = 3'd1;
  localparam cmd_t CMD_JMP  = 3'd2;
  localparam cmd_t CMD_CALL = 3'd3;
  localparam cmd_t CMD_RET  = 3'd4;

endpackage

// File: rtl/ret_stack.sv
// Purpose : LIFO of return addresses (DEPTH x ADDR_W); no error handling, parent flags misuse.
// Latency : push/pop take effect at the next rising edge; top/full/empty are combinational on state.
// Backpressure: none; push when full and pop when empty are ignored. pop wins over push.
// Ports   : clk, reset (sync, active-low), push, pop, push_data -> top, full, empty.
module ret_stack
  import ctrl_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DEPTH  = DEF_STACK_DEPTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] push_data,
  output logic [ADDR_W-1:0] top,
  output logic              full,
  output logic              empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] CNT_FULL = (PTR_W+1)'(DEPTH);

  logic [ADDR_W-1:0] mem [DEPTH];
  logic [PTR_W:0]    sp;        // number of valid entries
  logic [PTR_W-1:0]  wr_idx;
  logic [PTR_W-1:0]  top_idx;

  assign wr_idx  = sp[PTR_W-1:0];
  assign top_idx = wr_idx - 1'b1;   // wraps when empty; top is don't-care then
  assign top     = mem[top_idx];
  assign full    = (sp == CNT_FULL);
  assign empty   = (sp == '0);

  always_ff @(posedge clk) begin
    if (!reset) begin
      sp <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (pop && !empty) begin
      sp <= sp - 1'b1;
    end else if (push && !full) begin
      mem[wr_idx] <= push_data;
      sp          <= sp + 1'b1;
    end
  end

endmodule

// File: rtl/addr_sequencer.sv
// Purpose : PC / MAR / return-stack address generator feeding MemController's Addr_in.
// Latency : one edge from strobe to pc and Addr_in (Addr_in registered from the next-state values).
// Backpressure: increment waits for ready (held in inc_pending); jumps, calls and rets ignore ready.
// Ports   : clk, reset (sync, active-low), increment, addrn, datarn, call, ret, fetch, ready,
//           literal -> Addr_in, pc, inc_pending, stack_err.
module addr_sequencer
  import ctrl_pkg::*;
#(
  parameter int                ADDR_W      = DEF_ADDR_W,
  parameter int                LIT_W       = DEF_LIT_W,
  parameter logic [ADDR_W-1:0] RESET_PC    = ADDR_W'(DEF_RESET_PC),
  parameter int                STACK_DEPTH = DEF_STACK_DEPTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              increment,
  input  logic              addrn,
  input  logic              datarn,
  input  logic              call,
  input  logic              ret,
  input  logic              fetch,
  input  logic              ready,
  input  logic [LIT_W-1:0]  literal,
  output logic [ADDR_W-1:0] Addr_in,
  output logic [ADDR_W-1:0] pc,
  output logic              inc_pending,
  output logic              stack_err
);

  logic [ADDR_W-1:0] pc_q, mar_q;
  logic [ADDR_W-1:0] pc_next, mar_next;
  logic              pend_next, err_next;
  logic [ADDR_W-1:0] lit_addr, pc_plus1;
  logic              stk_push, stk_pop, stk_full, stk_empty;
  logic [ADDR_W-1:0] stk_top;
  cmd_t              cmd;

  // Upper literal bits carry opcode/immediate data for other stages.
  logic unused_lit_hi;
  assign unused_lit_hi = ^literal[LIT_W-1:ADDR_W];

  assign lit_addr = literal[ADDR_W-1:0];
  assign pc_plus1 = pc_q + 1'b1;     // natural modulo-2^ADDR_W wrap
  assign pc       = pc_q;

  // Priority: ret > call > addrn > (increment or pending advance).
  always_comb begin
    cmd = CMD_NONE;
    if (ret)                         cmd = CMD_RET;
    else if (call)                   cmd = CMD_CALL;
    else if (addrn)                  cmd = CMD_JMP;
    else if (increment || inc_pending) cmd = CMD_INC;
  end

  always_comb begin
    pc_next   = pc_q;
    mar_next  = mar_q;
    pend_next = inc_pending;
    err_next  = stack_err;
    stk_push  = 1'b0;
    stk_pop   = 1'b0;

    case (cmd)
      CMD_RET: begin
        pend_next = 1'b0;
        if (stk_empty) begin
          err_next = 1'b1;
        end else begin
          pc_next = stk_top;
          stk_pop = 1'b1;
        end
      end
      CMD_CALL: begin
        pend_next = 1'b0;
        if (stk_full) begin
          err_next = 1'b1;
        end else begin
          pc_next  = lit_addr;
          stk_push = 1'b1;
        end
      end
      CMD_JMP: begin
        pend_next = 1'b0;
        pc_next   = lit_addr;
      end
      CMD_INC: begin
        // A new increment on top of a pending one still yields one advance.
        if (ready) begin
          pc_next   = pc_plus1;
          pend_next = 1'b0;
        end else begin
          pend_next = 1'b1;
        end
      end
      default: ;
    endcase

    if (datarn) mar_next = lit_addr;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_q        <= RESET_PC;
      mar_q       <= '0;
      Addr_in     <= RESET_PC;
      inc_pending <= 1'b0;
      stack_err   <= 1'b0;
    end else begin
      pc_q        <= pc_next;
      mar_q       <= mar_next;
      Addr_in     <= fetch ? pc_next : mar_next;
      inc_pending <= pend_next;
      stack_err   <= err_next;
    end
  end

  ret_stack #(
    .ADDR_W (ADDR_W),
    .DEPTH  (STACK_DEPTH)
  ) u_ret_stack (
    .clk       (clk),
    .reset     (reset),
    .push      (stk_push),
    .pop       (stk_pop),
    .push_data (pc_plus1),
    .top       (stk_top),
    .full      (stk_full),
    .empty     (stk_empty)
  );

endmodule

// File: tb/tb_addr_sequencer.sv
// Purpose : self-checking bench for addr_sequencer: directed table, hand sequences, random vs model.
// Latency : checks one edge after each applied input set.
// Backpressure: ready driven directly by the bench.
module tb_addr_sequencer;
  import ctrl_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset, increment, addrn, datarn, call, ret, fetch, ready;
  logic [31:0] literal;
  logic [7:0]  Addr_in, pc;
  logic        inc_pending, stack_err;

  int tests = 0;
  int fails = 0;

  addr_sequencer dut (
    .clk(clk), .reset(reset), .increment(increment), .addrn(addrn), .datarn(datarn),
    .call(call), .ret(ret), .fetch(fetch), .ready(ready), .literal(literal),
    .Addr_in(Addr_in), .pc(pc), .inc_pending(inc_pending), .stack_err(stack_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst, inc, adr, dat, cal, rt, fet, rdy;
    logic [31:0] lit;
    logic [7:0]  e_pc, e_addr;
    logic        e_pend, e_err;
  } vec_t;

  function automatic vec_t mk(logic rst, logic inc, logic adr, logic dat, logic cal, logic rt,
                              logic fet, logic rdy, logic [31:0] lit,
                              logic [7:0] e_pc, logic [7:0] e_addr, logic e_pend, logic e_err);
    vec_t v;
    v.rst = rst; v.inc = inc; v.adr = adr; v.dat = dat; v.cal = cal; v.rt = rt;
    v.fet = fet; v.rdy = rdy; v.lit = lit;
    v.e_pc = e_pc; v.e_addr = e_addr; v.e_pend = e_pend; v.e_err = e_err;
    return v;
  endfunction

  // Behavioural model: integers mod 256 and a queue for the return stack.
  int m_pc = 0, m_mar = 0, m_addr = 0;
  bit m_pend = 0, m_err = 0;
  int m_stk[$];

  task automatic model_step();
    int nxt;
    if (!reset) begin
      m_pc = 0; m_mar = 0; m_addr = 0; m_pend = 0; m_err = 0;
      m_stk.delete();
      return;
    end
    nxt = m_pc;
    if (ret) begin
      m_pend = 0;
      if (m_stk.size() == 0) m_err = 1;
      else nxt = m_stk.pop_back();
    end else if (call) begin
      m_pend = 0;
      if (m_stk.size() == DEPTH) m_err = 1;
      else begin
        m_stk.push_back((m_pc + 1) % 256);
        nxt = int'(literal % 256);
      end
    end else if (addrn) begin
      m_pend = 0;
      nxt = int'(literal % 256);
    end else if (increment || m_pend) begin
      if (ready) begin
        nxt = (m_pc + 1) % 256;
        m_pend = 0;
      end else m_pend = 1;
    end
    if (datarn) m_mar = int'(literal % 256);
    m_pc = nxt;
    m_addr = fetch ? m_pc : m_mar;
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(vec_t v);
    reset = v.rst; increment = v.inc; addrn = v.adr; datarn = v.dat;
    call = v.cal; ret = v.rt; fetch = v.fet; ready = v.rdy; literal = v.lit;
  endtask

  // Apply one vector for one edge, then compare against its expected fields.
  task automatic apply(string name, vec_t v);
    drive(v);
    model_step();
    @(posedge clk); #1;
    chk({name, ".pc"},          32'(pc),          32'(v.e_pc));
    chk({name, ".Addr_in"},     32'(Addr_in),     32'(v.e_addr));
    chk({name, ".inc_pending"}, 32'(inc_pending), 32'(v.e_pend));
    chk({name, ".stack_err"},   32'(stack_err),   32'(v.e_err));
  endtask

  vec_t tbl[24];

  initial begin
    drive(mk(0,0,0,0,0,0,1,0,0, 0,0,0,0));

    //           rst inc adr dat cal ret fet rdy lit           pc     addr  pend err
    tbl[0]  = mk(0,  1,  0,  0,  0,  0,  1,  0,  32'hFA,       8'h00, 8'h00, 0, 0);
    tbl[1]  = mk(0,  1,  0,  0,  0,  0,  1,  1,  32'hFA,       8'h00, 8'h00, 0, 0);
    tbl[2]  = mk(1,  0,  0,  0,  0,  0,  1,  0,  32'hFA,       8'h00, 8'h00, 0, 0);
    tbl[3]  = mk(1,  1,  0,  0,  0,  0,  1,  0,  32'h0,        8'h00, 8'h00, 1, 0);
    tbl[4]  = mk(1,  1,  0,  0,  0,  0,  1,  0,  32'h0,        8'h00, 8'h00, 1, 0);
    tbl[5]  = mk(1,  1,  0,  0,  0,  0,  1,  0,  32'h0,        8'h00, 8'h00, 1, 0);
    tbl[6]  = mk(1,  0,  0,  0,  0,  0,  1,  1,  32'h0,        8'h01, 8'h01, 0, 0);
    tbl[7]  = mk(1,  0,  0,  0,  0,  0,  1,  1,  32'h0,        8'h01, 8'h01, 0, 0);
    tbl[8]  = mk(1,  0,  1,  0,  0,  0,  1,  0,  32'h000001FF, 8'hFF, 8'hFF, 0, 0);
    tbl[9]  = mk(1,  1,  0,  0,  0,  0,  1,  1,  32'h0,        8'h00, 8'h00, 0, 0);
    tbl[10] = mk(1,  0,  0,  1,  0,  0,  0,  0,  32'hFA,       8'h00, 8'hFA, 0, 0);
    tbl[11] = mk(1,  0,  0,  0,  0,  0,  1,  0,  32'h0,        8'h00, 8'h00, 0, 0);
    tbl[12] = mk(1,  1,  0,  0,  0,  0,  1,  0,  32'h0,        8'h00, 8'h00, 1, 0);
    tbl[13] = mk(1,  1,  0,  0,  0,  0,  1,  1,  32'h0,        8'h01, 8'h01, 0, 0);
    tbl[14] = mk(1,  0,  1,  0,  0,  0,  1,  0,  32'hABCD0010, 8'h10, 8'h10, 0, 0);
    tbl[15] = mk(1,  0,  0,  0,  1,  0,  1,  0,  32'h40,       8'h40, 8'h40, 0, 0);
    tbl[16] = mk(1,  0,  0,  0,  1,  0,  1,  0,  32'h60,       8'h60, 8'h60, 0, 0);
    tbl[17] = mk(1,  0,  0,  0,  0,  1,  1,  0,  32'h0,        8'h41, 8'h41, 0, 0);
    tbl[18] = mk(1,  0,  0,  0,  0,  1,  1,  0,  32'h0,        8'h11, 8'h11, 0, 0);
    tbl[19] = mk(1,  0,  0,  0,  0,  1,  1,  0,  32'h0,        8'h11, 8'h11, 0, 1);
    tbl[20] = mk(1,  1,  0,  0,  0,  0,  1,  0,  32'h0,        8'h11, 8'h11, 1, 1);
    tbl[21] = mk(1,  0,  1,  1,  0,  0,  0,  0,  32'h20,       8'h20, 8'h20, 0, 1);
    tbl[22] = mk(1,  0,  0,  0,  0,  0,  1,  1,  32'h0,        8'h20, 8'h20, 0, 1);
    tbl[23] = mk(0,  0,  0,  0,  0,  0,  1,  0,  32'h0,        8'h00, 8'h00, 0, 0);

    for (int i = 0; i < 24; i++) apply($sformatf("tbl%0d", i), tbl[i]);

    // Simultaneous call+ret after three pushes, then fill to overflow.
    apply("c1",      mk(1,0,0,0,1,0,1,0, 32'h10, 8'h10, 8'h10, 0, 0));
    apply("c2",      mk(1,0,0,0,1,0,1,0, 32'h20, 8'h20, 8'h20, 0, 0));
    apply("c3",      mk(1,0,0,0,1,0,1,0, 32'h30, 8'h30, 8'h30, 0, 0));
    apply("callret", mk(1,0,0,0,1,1,1,0, 32'h55, 8'h21, 8'h21, 0, 0));
    apply("c4",      mk(1,0,0,0,1,0,1,0, 32'h40, 8'h40, 8'h40, 0, 0));
    apply("c5",      mk(1,0,0,0,1,0,1,0, 32'h50, 8'h50, 8'h50, 0, 0));
    apply("ovf",     mk(1,0,0,0,1,0,1,1, 32'h77, 8'h50, 8'h50, 0, 1));
    apply("ret_ovf", mk(1,0,0,0,0,1,1,0, 32'h0,  8'h41, 8'h41, 0, 1));
    apply("rst2",    mk(0,0,0,0,0,0,1,0, 32'h0,  8'h00, 8'h00, 0, 0));

    // Randomized traffic against the behavioural model.
    for (int n = 0; n < 3000; n++) begin
      reset     = ($urandom_range(0, 99) != 0);
      increment = ($urandom_range(0, 2) == 0);
      addrn     = ($urandom_range(0, 7) == 0);
      datarn    = ($urandom_range(0, 3) == 0);
      call      = ($urandom_range(0, 7) == 0);
      ret       = ($urandom_range(0, 7) == 0);
      fetch     = ($urandom_range(0, 3) != 0);
      ready     = ($urandom_range(0, 1) == 0);
      literal   = $urandom;
      model_step();
      @(posedge clk); #1;
      chk($sformatf("rnd%0d.pc", n),          32'(pc),          32'(m_pc));
      chk($sformatf("rnd%0d.Addr_in", n),     32'(Addr_in),     32'(m_addr));
      chk($sformatf("rnd%0d.inc_pending", n), 32'(inc_pending), 32'(m_pend));
      chk($sformatf("rnd%0d.stack_err", n),   32'(stack_err),   32'(m_err));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/addr_sequencer.md
Name: addr_sequencer

Overview:
- Address-generation stage sitting directly downstream of the Control block and upstream of MemController.
- Consumes Control's sequencing strobes (increment, addrn, datarn, fetch) and its literal bus.
- Holds the program counter, the data memory-address register and a small return-address stack.
- Drives the 8-bit Addr_in that MemController forwards to Ram.

Parameters:
ADDR_W, 8, width of PC, MAR, stack entries and Addr_in
LIT_W, 32, width of the literal bus from Control
RESET_PC, 8'h00, PC value loaded on reset
STACK_DEPTH, 4, return-stack entries (power of two, >=2)

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-low reset (reset==0 at a rising edge resets all state)
increment  input  1  advance PC by one (from Control)
addrn  input  1  jump: PC <= literal[ADDR_W-1:0]
datarn  input  1  MAR <= literal[ADDR_W-1:0] (data operand address)
call  input  1  push PC+1, then PC <= literal[ADDR_W-1:0]
ret  input  1  PC <= popped stack entry
fetch  input  1  1: Addr_in sources PC; 0: Addr_in sources MAR
ready  input  1  MemController transaction-complete strobe
literal  input  LIT_W  immediate/address bus from Control
Addr_in  output  ADDR_W  registered address to MemController
pc  output  ADDR_W  current PC
inc_pending  output  1  an increment is waiting for ready
stack_err  output  1  sticky overflow/underflow flag

Behaviour:
- Reset (reset==0 at a clock edge): pc=RESET_PC, MAR=0, Addr_in=RESET_PC, stack pointer=0 (empty), stack contents=0, inc_pending=0, stack_err=0. Reset overrides every other input in the same cycle, including mid-transaction. There is no asynchronous path.
- Each edge evaluates PC commands in priority order ret > call > addrn > increment. Exactly one PC update occurs per cycle.
- increment handshake:
  - Takes effect only when ready==1 in the same cycle.
  - increment with ready==0 sets inc_pending=1.
  - While inc_pending==1, the first cycle with ready==1 performs PC+1 and clears inc_pending.
  - increment plus an existing pending request still yields a single +1.
- ret, call and addrn apply immediately regardless of ready, and clear inc_pending (a jump discards a pending sequential advance).
- call:
  - If the stack is not full: push (pc+1) mod 2^ADDR_W, pc <= literal[ADDR_W-1:0].
  - If the stack is full (STACK_DEPTH entries): no push, no PC change, stack_err <= 1.
- ret:
  - If the stack is not empty: pc <= top entry, pop.
  - If the stack is empty: no PC change, stack_err <= 1.
- call and ret in the same cycle: ret wins; call is ignored entirely, with no error.
- PC arithmetic is modulo 2^ADDR_W: 8'hFF + 1 -> 8'h00, with no flag. The upper literal bits [LIT_W-1:ADDR_W] are ignored.
- datarn is independent of the PC commands: MAR updates in the same cycle as any PC command.
- Addr_in is registered. Each edge: Addr_in <= fetch ? pc_next : mar_next, where *_next is the value being written that edge. A jump or datarn is therefore visible on Addr_in one cycle after the strobe, i.e. zero extra latency relative to pc.
- stack_err clears only on reset.
- pc output always equals the PC register.

Decomposition:
- Shared package (ctrl_pkg):
  - ADDR_W and LIT_W defaults.
  - RESET_PC.
  - Localparam encodings of the PC-command priority (CMD_NONE, CMD_INC, CMD_JMP, CMD_CALL, CMD_RET) for reuse by Control and the bench.
- Sub-module ret_stack: a LIFO of STACK_DEPTH x ADDR_W with push, pop, full, empty and top outputs. It performs no internal error handling; the parent raises stack_err.
- PC and MAR logic live in the top module.

Test Plan:
- Reset: hold reset=0 for 2 edges with increment=1 and literal=32'hFA -> pc=00, Addr_in=00, inc_pending=0, stack_err=0. Release reset -> values unchanged until a command arrives.
- Increment handshake: increment=1, ready=0 for 3 cycles -> pc stays 00, inc_pending=1. Then ready=1 for one cycle -> pc=01, inc_pending=0. No double advance.
- Jump and wrap: addrn=1 with literal=32'h000001FF -> pc=FF and Addr_in=FF (fetch=1) one edge later. Then increment with ready=1 -> pc=00.
- Data address: fetch=0, datarn=1, literal=32'hFA -> Addr_in=FA next edge while pc is unchanged. Then fetch=1 -> Addr_in returns to pc.
- Call/ret: at pc=10, call with literal=40 -> pc=40. Call at 40 with literal=60 -> pc=60. ret -> pc=41. ret -> pc=11. ret again -> pc=11, stack_err=1 (underflow).
- Overflow: perform 4 calls, then a 5th call with literal=77 -> pc unchanged, stack_err=1. Simultaneous call+ret -> the pop occurs and no error is added.
